// File: rtl/cr16_display_pkg.sv
// Shared types and constants for the CR16 display-side BRAM scanner.
package cr16_display_pkg;

    typedef enum logic [1:0] {
        S_LIVE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } scan_state_t;

    localparam int P_DISPLAY_BIT_WIDTH = 24;
    localparam int P_NIBBLE_COUNT      = 6;

endpackage

// File: rtl/step_pulse_gen.sv
// Turns the asynchronous step pushbutton into a single-cycle pulse.
// Define BRAM_SCANNER_DEBOUNCE_EN to require a stable level before a press counts.
module step_pulse_gen #(
    parameter int P_DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic I_CLK,
    input  logic I_RESET,
    input  logic I_BUTTON,
    output logic O_PULSE
);

    logic [1:0] sync_reg;
    logic       level;
    logic       level_prev_reg;

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], I_BUTTON};
        end
    end

`ifdef BRAM_SCANNER_DEBOUNCE_EN
    localparam int COUNT_W = (P_DEBOUNCE_CYCLES > 1) ? $clog2(P_DEBOUNCE_CYCLES) : 1;
    localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(P_DEBOUNCE_CYCLES - 1);

    logic [COUNT_W-1:0] stable_count_reg;
    logic               debounced_reg;

    // The level only flips after P_DEBOUNCE_CYCLES consecutive disagreeing samples,
    // so both short presses and short releases are filtered out.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            stable_count_reg <= '0;
            debounced_reg    <= 1'b0;
        end else if (sync_reg[1] == debounced_reg) begin
            stable_count_reg <= '0;
        end else if (stable_count_reg == COUNT_LAST) begin
            stable_count_reg <= '0;
            debounced_reg    <= sync_reg[1];
        end else begin
            stable_count_reg <= stable_count_reg + 1'b1;
        end
    end

    assign level = debounced_reg;
`else
    assign level = sync_reg[1];
`endif

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            level_prev_reg <= 1'b0;
        end else begin
            level_prev_reg <= level;
        end
    end

    assign O_PULSE = level & ~level_prev_reg;

endmodule

// File: rtl/bram_display_scanner.sv
// Registered display source: live core bits while running, BRAM port B walk once halted.
// Optional step debounce is enabled with BRAM_SCANNER_DEBOUNCE_EN.
module bram_display_scanner
    import cr16_display_pkg::*;
#(
    parameter int P_ADDRESS_WIDTH   = 10,
    parameter int P_DATA_WIDTH      = 16,
    parameter int P_SCAN_START      = 0,
    parameter int P_SCAN_END        = 1023,
    parameter int P_SCAN_TICKS      = 50_000_000,
    parameter int P_DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                           I_CLK,
    input  logic                           I_RESET,
    input  logic                           I_HALTED,
    input  logic                           I_AUTO,
    input  logic                           I_STEP,
    input  logic [P_ADDRESS_WIDTH-1:0]     I_MANUAL_ADDRESS,
    input  logic [P_DISPLAY_BIT_WIDTH-1:0] I_LIVE_BITS,
    input  logic [P_DATA_WIDTH-1:0]        I_MEM_DATA,
    output logic [P_ADDRESS_WIDTH-1:0]     O_MEM_ADDRESS,
    output logic [P_DISPLAY_BIT_WIDTH-1:0] O_DISPLAY_BITS,
    output logic                           O_VALID,
    output logic                           O_SCAN_ACTIVE
);

    localparam int TICK_W = (P_SCAN_TICKS > 1) ? $clog2(P_SCAN_TICKS) : 1;
    localparam logic [TICK_W-1:0]          TICK_LAST  = TICK_W'(P_SCAN_TICKS - 1);
    localparam logic [P_ADDRESS_WIDTH-1:0] SCAN_START = P_ADDRESS_WIDTH'(P_SCAN_START);
    localparam logic [P_ADDRESS_WIDTH-1:0] SCAN_END   = P_ADDRESS_WIDTH'(P_SCAN_END);

    scan_state_t                    state_reg;
    logic [P_ADDRESS_WIDTH-1:0]     address_reg;
    logic [P_DISPLAY_BIT_WIDTH-1:0] display_reg;
    logic                           valid_reg;
    logic [TICK_W-1:0]              tick_reg;

    logic                       step_pulse;
    logic                       advance;
    logic [P_ADDRESS_WIDTH-1:0] auto_next;
    logic [P_ADDRESS_WIDTH-1:0] advance_address;

    step_pulse_gen #(
        .P_DEBOUNCE_CYCLES(P_DEBOUNCE_CYCLES)
    ) u_step_pulse_gen (
        .I_CLK   (I_CLK),
        .I_RESET (I_RESET),
        .I_BUTTON(I_STEP),
        .O_PULSE (step_pulse)
    );

    // Tick and step are ORed, so a coincident pair still yields a single advance.
    always_comb begin
        auto_next       = (address_reg == SCAN_END) ? SCAN_START : address_reg + 1'b1;
        advance         = 1'b0;
        advance_address = auto_next;
        if (I_AUTO) begin
            advance = (tick_reg == TICK_LAST) || step_pulse;
        end else begin
            advance         = (I_MANUAL_ADDRESS != address_reg);
            advance_address = I_MANUAL_ADDRESS;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_reg   <= S_LIVE;
            address_reg <= SCAN_START;
            display_reg <= '0;
            valid_reg   <= 1'b0;
            tick_reg    <= '0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                S_LIVE: begin
                    display_reg <= I_LIVE_BITS;
                    if (I_HALTED) begin
                        address_reg <= I_AUTO ? SCAN_START : I_MANUAL_ADDRESS;
                        state_reg   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    state_reg <= I_HALTED ? S_CAPTURE : S_LIVE;
                end
                S_CAPTURE: begin
                    if (!I_HALTED) begin
                        state_reg <= S_LIVE;
                    end else begin
                        display_reg <= P_DISPLAY_BIT_WIDTH'({address_reg[7:0], I_MEM_DATA});
                        valid_reg   <= 1'b1;
                        tick_reg    <= '0;
                        state_reg   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!I_HALTED) begin
                        state_reg <= S_LIVE;
                    end else if (advance) begin
                        address_reg <= advance_address;
                        state_reg   <= S_WAIT;
                    end else if (I_AUTO) begin
                        tick_reg <= tick_reg + 1'b1;
                    end else begin
                        // Manual hold restarts the period so a later switch to auto gets a full dwell.
                        tick_reg <= '0;
                    end
                end
                default: state_reg <= S_LIVE;
            endcase
        end
    end

    assign O_MEM_ADDRESS  = address_reg;
    assign O_DISPLAY_BITS = display_reg;
    assign O_VALID        = valid_reg;
    assign O_SCAN_ACTIVE  = (state_reg != S_LIVE);

endmodule
